// File: rtl/lamp_monitor.sv
// Traffic-lamp safety monitor: forwards controller lamp commands while they are legal.
// On the first fault it latches the fault code and flashes red on both directions.
// Define LAMP_MONITOR_FCOUNT_EN to add the FCOUNT output, which counts fault entries.
module lamp_monitor #(
  parameter int MIN_YLW   = 3,
  parameter int MAX_DARK  = 2,
  parameter int FLASH_DIV = 4
) (
  input  logic       CK,
  input  logic       CLRN,
  input  logic       GRN1,
  input  logic       YLW1,
  input  logic       RED1,
  input  logic       GRN2,
  input  logic       YLW2,
  input  logic       RED2,
  input  logic       ACK,
  output logic [2:0] LAMP1,
  output logic [2:0] LAMP2,
  output logic       FAULT,
  output logic [2:0] FCODE
`ifdef LAMP_MONITOR_FCOUNT_EN
  ,
  output logic [7:0] FCOUNT
`endif
);

  localparam logic [3:0] MIN_YLW_C  = 4'(MIN_YLW);
  localparam logic [3:0] MAX_DARK_C = 4'(MAX_DARK);
  localparam logic [7:0] FLASH_LAST = 8'(FLASH_DIV - 1);
  localparam logic [2:0] RED_ONLY   = 3'b001;

  typedef enum logic [1:0] {IDLE, RUN, FLT} state_t;

  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  function automatic logic multi_lit(input logic [2:0] v);
    return (v[2] & v[1]) | (v[2] & v[0]) | (v[1] & v[0]);
  endfunction

  state_t     state;
  logic [2:0] lamp_in1;
  logic [2:0] lamp_in2;
  logic       both_red;
  logic [3:0] ylw_cnt1;
  logic [3:0] ylw_cnt2;
  logic [3:0] dark_cnt1;
  logic [3:0] dark_cnt2;
  logic       prev_grn1;
  logic       prev_grn2;
  logic       flash;
  logic [7:0] flash_cnt;
  logic [2:0] code;

  assign lamp_in1 = {GRN1, YLW1, RED1};
  assign lamp_in2 = {GRN2, YLW2, RED2};
  assign both_red = (lamp_in1 == RED_ONLY) && (lamp_in2 == RED_ONLY);

  // Lamp history: counters hold the run length up to the previous cycle.
  always_ff @(posedge CK or negedge CLRN) begin
    if (!CLRN) begin
      ylw_cnt1  <= 4'd0;
      ylw_cnt2  <= 4'd0;
      dark_cnt1 <= 4'd0;
      dark_cnt2 <= 4'd0;
      prev_grn1 <= 1'b0;
      prev_grn2 <= 1'b0;
    end else begin
      ylw_cnt1  <= YLW1 ? sat_inc4(ylw_cnt1) : 4'd0;
      ylw_cnt2  <= YLW2 ? sat_inc4(ylw_cnt2) : 4'd0;
      dark_cnt1 <= (lamp_in1 == 3'b000) ? sat_inc4(dark_cnt1) : 4'd0;
      dark_cnt2 <= (lamp_in2 == 3'b000) ? sat_inc4(dark_cnt2) : 4'd0;
      prev_grn1 <= GRN1;
      prev_grn2 <= GRN2;
    end
  end

  // Fault checks in priority order, so the lowest code wins.
  always_comb begin
    code = 3'd0;
    if ((GRN1 | YLW1) && (GRN2 | YLW2)) begin
      code = 3'd1;
    end else if (multi_lit(lamp_in1) || multi_lit(lamp_in2)) begin
      code = 3'd2;
    end else if (((lamp_in1 == 3'b000) && (dark_cnt1 >= MAX_DARK_C)) ||
                 ((lamp_in2 == 3'b000) && (dark_cnt2 >= MAX_DARK_C))) begin
      code = 3'd3;
    end else if ((!YLW1 && (ylw_cnt1 != 4'd0) && (ylw_cnt1 < MIN_YLW_C)) ||
                 (!YLW2 && (ylw_cnt2 != 4'd0) && (ylw_cnt2 < MIN_YLW_C))) begin
      code = 3'd4;
    end else if ((prev_grn1 && RED1) || (prev_grn2 && RED2)) begin
      code = 3'd5;
    end
  end

  always_ff @(posedge CK or negedge CLRN) begin
    if (!CLRN) begin
      state     <= IDLE;
      LAMP1     <= RED_ONLY;
      LAMP2     <= RED_ONLY;
      FAULT     <= 1'b0;
      FCODE     <= 3'd0;
      flash     <= 1'b1;
      flash_cnt <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          LAMP1 <= RED_ONLY;
          LAMP2 <= RED_ONLY;
          if (both_red) state <= RUN;
        end
        RUN: begin
          if (code != 3'd0) begin
            state     <= FLT;
            FAULT     <= 1'b1;
            FCODE     <= code;
            flash     <= 1'b1;
            flash_cnt <= 8'd0;
            LAMP1     <= RED_ONLY;
            LAMP2     <= RED_ONLY;
          end else begin
            LAMP1 <= lamp_in1;
            LAMP2 <= lamp_in2;
          end
        end
        FLT: begin
          if (ACK && both_red) begin
            state     <= IDLE;
            FAULT     <= 1'b0;
            FCODE     <= 3'd0;
            flash     <= 1'b1;
            flash_cnt <= 8'd0;
            LAMP1     <= RED_ONLY;
            LAMP2     <= RED_ONLY;
          end else if (flash_cnt == FLASH_LAST) begin
            flash_cnt <= 8'd0;
            flash     <= ~flash;
            LAMP1     <= {2'b00, ~flash};
            LAMP2     <= {2'b00, ~flash};
          end else begin
            flash_cnt <= flash_cnt + 8'd1;
            LAMP1     <= {2'b00, flash};
            LAMP2     <= {2'b00, flash};
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef LAMP_MONITOR_FCOUNT_EN
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  always_ff @(posedge CK or negedge CLRN) begin
    if (!CLRN) begin
      FCOUNT <= 8'd0;
    end else if ((state == RUN) && (code != 3'd0)) begin
      FCOUNT <= sat_inc8(FCOUNT);
    end
  end
`endif

endmodule

// File: doc/lamp_monitor.md
LAMP_MONITOR -- requirements
Module: lamp_monitor

Interface
REQ-001 SHALL have parameter MIN_YLW, default 3, minimum legal yellow run length in cycles (range 1..15).
REQ-002 SHALL have parameter MAX_DARK, default 2, maximum consecutive cycles a direction may show no lamp (range 1..15).
REQ-003 SHALL have parameter FLASH_DIV, default 4, number of cycles per half-period of the fault flash (range 1..255).
REQ-004 SHALL have port CK  input  1  the single clock; all logic is rising-edge.
REQ-005 SHALL have port CLRN  input  1  reset, asynchronous and active-low.
REQ-006 SHALL have ports GRN1, YLW1, RED1, GRN2, YLW2, RED2  input  1 each  raw lamp commands from the traffic controller, synchronous to CK.
REQ-007 SHALL have port ACK  input  1  operator fault acknowledge, single-cycle pulse.
REQ-008 SHALL have port LAMP1  output  3  safe lamp drive for direction 1, bit order {G,Y,R}.
REQ-009 SHALL have port LAMP2  output  3  safe lamp drive for direction 2, bit order {G,Y,R}.
REQ-010 SHALL have port FAULT  output  1  high while the FLT state is active.
REQ-011 SHALL have port FCODE  output  3  latched code of the first fault; 0 means none.

Function
REQ-012 SHALL implement the FSM states IDLE, RUN and FLT, with all outputs registered.
REQ-013 In IDLE, SHALL drive LAMP1 = LAMP2 = 3'b001 (all red).
REQ-014 SHALL go from IDLE to RUN on the first cycle where both directions show exactly RED only.
REQ-015 In RUN, SHALL pass the inputs to LAMPn with exactly 1 cycle latency.
REQ-016 In RUN, SHALL evaluate the fault checks below every cycle; any fault moves to FLT on the next edge.
REQ-017 SHALL raise code 1 (conflict) when (GRN1|YLW1) and (GRN2|YLW2) are both high.
REQ-018 SHALL raise code 2 (multi-lamp) when more than one of G/Y/R is high in either direction.
REQ-019 SHALL raise code 3 (dark) when a direction shows no lamp for MAX_DARK+1 consecutive cycles.
REQ-020 SHALL raise code 4 (short yellow) when YLWn falls after a yellow run shorter than MIN_YLW cycles.
REQ-021 SHALL raise code 5 (skipped yellow) when GRNn was high in the previous cycle and REDn is high in the current cycle.
REQ-022 SHALL latch the lowest code when several faults occur in the same cycle, and SHALL NOT overwrite FCODE while in FLT.
REQ-023 Yellow-run and dark counters SHALL be 4 bits per direction, saturating, and cleared whenever the monitored condition ends.
REQ-024 In FLT, SHALL drive LAMP1 = LAMP2 = {1'b0,1'b0,flash}, where flash starts at 1 on FLT entry and toggles every FLASH_DIV cycles using an 8-bit wrap counter.
REQ-025 In FLT, ACK SHALL move to IDLE and clear FCODE only if both directions show exactly RED only in that cycle; otherwise ACK is ignored.
REQ-026 SHALL have FAULT = 1 exactly while the state is FLT.

Reset
REQ-027 On CLRN low, SHALL asynchronously set: state IDLE, LAMP1 = LAMP2 = 3'b001, FAULT = 0, FCODE = 0, all counters 0, flash = 1.
REQ-028 Reset deassertion SHALL take effect at the next CK edge; reset asserted mid-fault SHALL abandon FLT unconditionally.

Configuration
REQ-029 With LAMP_MONITOR_FCOUNT_EN defined, SHALL add output FCOUNT  output  8  a count of RUN->FLT entries.
- FCOUNT saturates at 255, is reset to 0 by CLRN, and is not cleared by ACK.
REQ-030 Without LAMP_MONITOR_FCOUNT_EN, SHALL have no FCOUNT port and no counter logic.

Verification
REQ-031 Reset, then RED1 = RED2 = 1 for 1 cycle -> state RUN; a following legal sequence G1 -> Y1 (3 cycles) -> R1 appears on LAMP1 one cycle late; FAULT stays 0.
REQ-032 In RUN, GRN1 = 1 and GRN2 = 1 in the same cycle -> next cycle FAULT = 1, FCODE = 1, LAMP1 = LAMP2 = 3'b001, toggling to 3'b000 after 4 cycles.
REQ-033 In RUN, YLW2 high for 2 cycles then RED2 -> FCODE = 4; with MIN_YLW = 2 the same stimulus gives no fault.
REQ-034 In RUN, GRN1 -> RED1 with no yellow, while direction 2 simultaneously goes dark -> FCODE = 5, not 3 (dark takes 3 cycles, so only code 5 fires).
REQ-035 In FLT, ACK with GRN1 = 1 -> stays in FLT; ACK with RED1 = RED2 = 1 -> IDLE, FCODE = 0, LAMPn = 3'b001.
REQ-036 In FLT, pulse CLRN low -> immediate IDLE, FAULT = 0; with LAMP_MONITOR_FCOUNT_EN, 3 fault entries -> FCOUNT = 3, unchanged by ACK.
